// File: rtl/fp_alu.sv
// Single-cycle IEEE-754 single-precision ALU: add, subtract, multiply, divide.
// Add/sub truncates with no guard bits; multiply and divide round to nearest even.
module fp_alu (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  input  logic [1:0]  op,
  output logic [31:0] S
);

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Saturate to infinity or flush to zero when the exponent leaves the normal range.
  function automatic logic [31:0] pack(input logic s, input logic signed [10:0] e,
                                       input logic [22:0] f);
    if (e > 11'sd254)
      return {s, 8'hFF, 23'b0};
    else if (e < 11'sd1)
      return {s, 31'b0};
    else
      return {s, e[7:0], f};
  endfunction

  // Hidden bit is implied; an all-ones fraction that rounds up wraps to zero
  // and bumps the exponent.
  function automatic logic [31:0] round_pack(input logic s, input logic signed [10:0] e,
                                             input logic [22:0] f, input logic g,
                                             input logic st);
    logic        up;
    logic        carry;
    logic [22:0] fr;
    up    = g & (st | f[0]);
    carry = up & (&f);
    fr    = f + {22'b0, up};
    return pack(s, carry ? e + 11'sd1 : e, fr);
  endfunction

  op_e         opc;
  logic        s1, s2;
  logic [7:0]  e1, e2;
  logic [22:0] f1, f2;
  logic [23:0] m1, m2;
  logic        nan1, nan2, inf1, inf2, zero1, zero2;
  logic        sx;

  assign opc   = op_e'(op);
  assign s1    = num1[31];
  assign s2    = num2[31];
  assign e1    = num1[30:23];
  assign e2    = num2[30:23];
  assign f1    = num1[22:0];
  assign f2    = num2[22:0];
  assign m1    = {1'b1, f1};
  assign m2    = {1'b1, f2};
  assign nan1  = (e1 == 8'hFF) && (f1 != '0);
  assign nan2  = (e2 == 8'hFF) && (f2 != '0);
  assign inf1  = (e1 == 8'hFF) && (f1 == '0);
  assign inf2  = (e2 == 8'hFF) && (f2 == '0);
  assign zero1 = (e1 == '0);
  assign zero2 = (e2 == '0);
  assign sx    = s1 ^ s2;

  // Add/sub datapath
  logic               sign2_eff;
  logic               swap;
  logic               big_s, sml_s;
  logic [7:0]         big_e, sml_e;
  logic [23:0]        big_m, sml_m, aligned;
  logic [24:0]        sum;
  logic [4:0]         lz;
  logic signed [10:0] big_exp;
  logic [31:0]        add_res;

  always_comb begin
    sign2_eff = s2 ^ (opc == OP_SUB);
    swap      = {e2, f2} > {e1, f1};
    big_s     = swap ? sign2_eff : s1;
    sml_s     = swap ? s1 : sign2_eff;
    big_e     = swap ? e2 : e1;
    sml_e     = swap ? e1 : e2;
    big_m     = swap ? m2 : m1;
    sml_m     = swap ? m1 : m2;
    big_exp   = $signed({3'b000, big_e});
    aligned   = sml_m >> (big_e - sml_e);
    if (big_s == sml_s)
      sum = {1'b0, big_m} + {1'b0, aligned};
    else
      sum = {1'b0, big_m} - {1'b0, aligned};
    lz = '0;
    for (int unsigned i = 0; i < 24; i++)
      if (sum[i]) lz = 5'(23 - i);
    if (sum == '0)
      add_res = '0;
    else if (sum[24])
      add_res = pack(big_s, big_exp + 11'sd1, sum[23:1]);
    else
      add_res = pack(big_s, big_exp - $signed({6'b0, lz}), 23'(sum[22:0] << lz));
  end

  // Multiply datapath
  logic [47:0]        prod;
  logic signed [10:0] mul_exp;
  logic [31:0]        mul_res;

  always_comb begin
    prod    = {24'b0, m1} * {24'b0, m2};
    mul_exp = $signed({3'b000, e1}) + $signed({3'b000, e2}) - 11'sd127;
    if (prod[47])
      mul_res = round_pack(sx, mul_exp + 11'sd1, prod[46:24], prod[23], |prod[22:0]);
    else
      mul_res = round_pack(sx, mul_exp, prod[45:23], prod[22], |prod[21:0]);
  end

  // Divide datapath: 28-bit quotient of num2/num1, remainder folds into sticky
  logic [50:0]        dividend;
  logic [27:0]        quot;
  logic [23:0]        rem;
  logic signed [10:0] div_exp;
  logic [31:0]        div_res;

  always_comb begin
    dividend = {m2, 27'b0};
    quot     = 28'(dividend / {27'b0, m1});
    rem      = 24'(dividend % {27'b0, m1});
    div_exp  = $signed({3'b000, e2}) - $signed({3'b000, e1}) + 11'sd127;
    if (quot[27])
      div_res = round_pack(sx, div_exp, quot[26:4], quot[3], (|quot[2:0]) | (rem != '0));
    else
      div_res = round_pack(sx, div_exp - 11'sd1, quot[25:3], quot[2],
                           (|quot[1:0]) | (rem != '0));
  end

  // Special-operand selection
  logic [31:0] result;

  always_comb begin
    result = QNAN;
    case (opc)
      OP_ADD, OP_SUB: begin
        if (nan1 || nan2)
          result = QNAN;
        else if (inf1 && inf2)
          result = (s1 != sign2_eff) ? QNAN : {s1, 8'hFF, 23'b0};
        else if (inf1)
          result = {s1, 8'hFF, 23'b0};
        else if (inf2)
          result = {sign2_eff, 8'hFF, 23'b0};
        else if (zero1 && zero2)
          result = {s1 & sign2_eff, 31'b0};
        else if (zero1)
          result = {sign2_eff, num2[30:0]};
        else if (zero2)
          result = num1;
        else
          result = add_res;
      end
      OP_MUL: begin
        if (nan1 || nan2)
          result = QNAN;
        else if ((zero1 && inf2) || (zero2 && inf1))
          result = QNAN;
        else if (inf1 || inf2)
          result = {sx, 8'hFF, 23'b0};
        else if (zero1 || zero2)
          result = {sx, 31'b0};
        else
          result = mul_res;
      end
      OP_DIV: begin
        if (nan1 || nan2)
          result = QNAN;
        else if ((inf1 && inf2) || (zero1 && zero2))
          result = QNAN;
        else if (zero1 || inf2)
          result = {sx, 8'hFF, 23'b0};
        else if (inf1 || zero2)
          result = {sx, 31'b0};
        else
          result = div_res;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn)
      S <= '0;
    else
      S <= result;
  end

endmodule

// File: tb/tb_fp_alu.sv
// Directed bench for fp_alu: reset behaviour, each operation, rounding ties and
// special operands, with hand-computed expected results.
module tb_fp_alu;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] num1, num2;
  logic [1:0]  op;
  logic [31:0] S;
  int          tests = 0;
  int          fails = 0;

  fp_alu dut (
    .clk  (clk),
    .rstn (rstn),
    .num1 (num1),
    .num2 (num2),
    .op   (op),
    .S    (S)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] expv);
    tests++;
    assert (S === expv) else begin
      fails++;
      $error("FAIL %s: S=%08h expected %08h", tag, S, expv);
    end
  endtask

  task automatic apply(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op   = o;
    num1 = a;
    num2 = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b1;
    op   = 2'd0;
    num1 = 32'h3F80_0000;
    num2 = 32'h3F80_0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset", 32'h0000_0000);

    rstn = 1'b0;
    apply(2'd0, 32'h4013_D70A, 32'h3F8F_5C29); check("add", 32'h405B_851E);
    @(posedge clk); #1;                         check("add_hold", 32'h405B_851E);
    apply(2'd1, 32'h3E9E_B852, 32'h3F8F_5C29); check("sub_trunc", 32'hBF4F_5C2A);
    apply(2'd2, 32'h3FC1_47AE, 32'h3F81_47AE); check("mul", 32'h3FC3_367A);
    apply(2'd3, 32'h3F9A_E148, 32'h3F8E_147B); check("div", 32'h3F6A_D7CD);
    apply(2'd3, 32'h0000_0000, 32'h3F80_0000); check("div_by_zero", 32'h7F80_0000);
    apply(2'd1, 32'h4000_0000, 32'h4000_0000); check("sub_cancel", 32'h0000_0000);
    apply(2'd2, 32'h7F00_0000, 32'h4040_0000); check("mul_ovf", 32'h7F80_0000);
    apply(2'd0, 32'h3F80_0000, 32'h3F80_0000); check("add_carry", 32'h4000_0000);
    apply(2'd0, 32'h3F80_0000, 32'hC000_0000); check("add_bigger_sign", 32'hBF80_0000);
    apply(2'd0, 32'h7F7F_FFFF, 32'h7F7F_FFFF); check("add_ovf", 32'h7F80_0000);
    apply(2'd3, 32'h0000_0000, 32'h0000_0000); check("div_zero_zero", 32'h7FC0_0000);
    apply(2'd3, 32'h4000_0000, 32'h8000_0000); check("div_zero_num", 32'h8000_0000);
    apply(2'd0, 32'h7F80_0001, 32'h3F80_0000); check("nan_in", 32'h7FC0_0000);
    apply(2'd1, 32'h7F80_0000, 32'h7F80_0000); check("inf_minus_inf", 32'h7FC0_0000);
    apply(2'd2, 32'h0000_0000, 32'h7F80_0000); check("zero_times_inf", 32'h7FC0_0000);
    apply(2'd3, 32'h7F80_0000, 32'h7F80_0000); check("inf_div_inf", 32'h7FC0_0000);
    apply(2'd1, 32'h0000_0000, 32'h4040_0000); check("zero_sub", 32'hC040_0000);
    apply(2'd2, 32'h8000_0000, 32'h4040_0000); check("mul_zero_sign", 32'h8000_0000);
    apply(2'd2, 32'h3F80_0001, 32'h4040_0000); check("mul_tie_up", 32'h4040_0002);
    apply(2'd2, 32'h3F80_0003, 32'h4040_0000); check("mul_tie_even", 32'h4040_0004);
    apply(2'd2, 32'h8080_0000, 32'h0080_0000); check("mul_underflow", 32'h8000_0000);
    apply(2'd0, 32'h4040_0000, 32'h0000_0001); check("denorm_as_zero", 32'h4040_0000);
    apply(2'd2, 32'h7F80_0000, 32'hC000_0000); check("inf_propagate", 32'hFF80_0000);

    rstn = 1'b1;
    apply(2'd2, 32'h3FC1_47AE, 32'h3F81_47AE); check("midreset", 32'h0000_0000);
    @(posedge clk); #1;                         check("midreset_hold", 32'h0000_0000);
    rstn = 1'b0;
    apply(2'd2, 32'h3FC1_47AE, 32'h3F81_47AE); check("after_reset", 32'h3FC3_367A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
